// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    typedef logic [15:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam word_t       NOP_WORD     = 16'h0000;
    localparam int unsigned IMM_FLAG_BIT = 2;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter: synchronous clear, parallel load, hold, or wrap-around increment.
module pc_register
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  hold,
    input  logic  load,
    input  addr_t load_value,
    output addr_t pc
);

    // Load wins over hold so a redirect can never be swallowed by a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (!hold) begin
            pc <= pc + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: boots the PC from the reset vector word, then streams words
// into the instruction register with stall, redirect flush and immediate tagging.
module fetch_stage #(
    parameter fetch_stage_pkg::addr_t RESET_VECTOR_ADDR = 16'h0000,
    parameter fetch_stage_pkg::word_t NOP_WORD          = fetch_stage_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    output logic        ir_imm
);

    import fetch_stage_pkg::*;

    state_t state, state_nxt;
    addr_t  pc;
    addr_t  pc_load_value;
    logic   pc_hold;
    logic   pc_load;
    logic   ir_load;
    logic   ir_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        imem_addr     = pc;
        pc_hold       = 1'b1;
        pc_load       = 1'b0;
        pc_load_value = redirect_pc;
        ir_load       = 1'b0;
        ir_flush      = 1'b0;
        case (state)
            BOOT: begin
                // The reset vector word holds the boot PC, not an instruction.
                imem_addr     = RESET_VECTOR_ADDR;
                pc_load       = 1'b1;
                pc_load_value = imem_rdata;
                state_nxt     = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_load  = 1'b1;
                    ir_flush = 1'b1;
                end else if (!stall) begin
                    pc_hold = 1'b0;
                    ir_load = 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    pc_register u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (pc_hold),
        .load       (pc_load),
        .load_value (pc_load_value),
        .pc         (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir       <= NOP_WORD;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            ir_imm   <= 1'b0;
        end else if (ir_flush) begin
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
            ir_imm   <= 1'b0;
        end else if (ir_load) begin
            // An opcode word flagged in bit IMM_FLAG_BIT makes the next word its immediate.
            ir_imm   <= ir_valid & ir[IMM_FLAG_BIT] & ~ir_imm;
            ir       <= imem_rdata;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [15:0] RV  = 16'h0000;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_imm;

    logic [15:0] mem [0:65535];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bit          m_boot  = 1'b1;
    bit          m_known = 1'b0;
    logic [15:0] m_pc    = '0;
    logic [15:0] m_ir    = '0;
    logic [15:0] m_ir_pc = '0;
    bit          m_valid = 1'b0;
    bit          m_imm   = 1'b0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    fetch_stage #(
        .RESET_VECTOR_ADDR (RV),
        .NOP_WORD          (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_imm      (ir_imm)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check fetch address, advance model, check registered outputs.
    task automatic step(input bit rstn, input bit stl, input bit rdr, input logic [15:0] rpc);
        logic [15:0] addr;
        rst_n       = rstn;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
        addr = m_boot ? RV : m_pc;
        if (m_known) check("imem_addr", imem_addr, addr);
        @(posedge clk);
        if (!rstn) begin
            m_boot = 1'b1; m_pc = '0; m_ir = NOP; m_ir_pc = '0; m_valid = 1'b0; m_imm = 1'b0;
        end else if (m_boot) begin
            m_pc   = mem[addr];
            m_boot = 1'b0;
        end else if (rdr) begin
            m_pc = rpc; m_ir = NOP; m_valid = 1'b0; m_imm = 1'b0;
        end else if (!stl) begin
            m_imm   = m_valid && m_ir[2] && !m_imm;
            m_ir    = mem[addr];
            m_ir_pc = addr;
            m_valid = 1'b1;
            m_pc    = 16'((32'(addr) + 1) % 65536);
        end
        m_known = 1'b1;
        #1;
        check("ir", ir, m_ir);
        check("ir_pc", ir_pc, m_ir_pc);
        check("ir_valid", {15'b0, ir_valid}, {15'b0, m_valid});
        check("ir_imm", {15'b0, ir_imm}, {15'b0, m_imm});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0]       = 16'h0010;
        mem[16]      = 16'hA000;
        mem[16'h200] = 16'hBEEF;
        mem[5]       = 16'h0004;
        mem[6]       = 16'h0004;
        mem[7]       = 16'h1234;

        // Reset, with stall/redirect asserted to show they are ignored.
        step(1'b0, 1'b1, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check("rst_ir", ir, NOP);
        check("rst_valid", {15'b0, ir_valid}, 16'd0);
        check("boot_addr", imem_addr, RV);

        // Boot sequence and first fetch latency.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("boot_pc", imem_addr, 16'h0010);
        check("first_valid_early", {15'b0, ir_valid}, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("first_ir", ir, 16'hA000);
        check("first_ir_pc", ir_pc, 16'h0010);
        check("first_valid", {15'b0, ir_valid}, 16'd1);

        // PC wrap-around.
        step(1'b1, 1'b0, 1'b1, 16'hFFFE);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wrap_pc0", ir_pc, 16'hFFFE);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wrap_pc1", ir_pc, 16'hFFFF);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("wrap_pc2", ir_pc, 16'h0000);

        // Three-cycle stall mid-stream.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0000);
            check("stall_ir_pc", ir_pc, 16'h0001);
            check("stall_ir", ir, mem[1]);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("resume_ir_pc", ir_pc, 16'h0002);

        // Redirect wins over stall.
        step(1'b1, 1'b1, 1'b1, 16'h0200);
        check("flush_ir", ir, NOP);
        check("flush_valid", {15'b0, ir_valid}, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("target_ir", ir, 16'hBEEF);
        check("target_ir_pc", ir_pc, 16'h0200);

        // Immediate-word tagging.
        step(1'b1, 1'b0, 1'b1, 16'h0005);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("imm5", {15'b0, ir_imm}, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("imm6", {15'b0, ir_imm}, 16'd1);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("imm7", {15'b0, ir_imm}, 16'd0);
        step(1'b1, 1'b0, 1'b1, 16'h0005);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 16'h0006);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("imm6_after_redirect_pc", ir_pc, 16'h0006);
        check("imm6_after_redirect", {15'b0, ir_imm}, 16'd0);

        // Reset during RUN with redirect asserted, then boot again.
        step(1'b0, 1'b0, 1'b1, 16'h0300);
        check("mid_rst_ir", ir, NOP);
        check("mid_rst_ir_pc", ir_pc, 16'h0000);
        check("mid_rst_valid", {15'b0, ir_valid}, 16'd0);
        check("mid_rst_addr", imem_addr, RV);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("reboot_pc", imem_addr, 16'h0010);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("reboot_ir", ir, 16'hA000);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) >= 2, $urandom_range(3) == 0,
                 $urandom_range(9) == 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
